// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: N_CH independent glitch-free gated clocks derived from in_clk.
// Each channel has a wake-up delay, a drain hold-off and a registered acknowledge.
// active_cnt reports how many channels currently have clk_ack set.
// Optional macro CLK_GATE_TEST_EN adds input test_en, which forces every gate open
// without disturbing the channel FSMs, clk_ack or active_cnt.
//
// state    | meaning
// ST_OFF   | clock gated, waiting for clk_en
// ST_WAKE  | request seen, waiting WAKE_CYC cycles before releasing the clock
// ST_ON    | clock running, request held
// ST_DRAIN | request dropped, keeping HOLD_CYC more pulses before gating
module clk_gate_ctrl #(
   parameter int N_CH     = 4,
   parameter int WAKE_CYC = 2,
   parameter int HOLD_CYC = 8,
   parameter int CNT_W    = 8
) (
   input  logic                          in_clk,
   input  logic                          rst_n,
`ifdef CLK_GATE_TEST_EN
   input  logic                          test_en,
`endif
   input  logic [N_CH-1:0]               clk_en,
   output logic [N_CH-1:0]               out_clk,
   output logic [N_CH-1:0]               clk_ack,
   output logic [$clog2(N_CH+1)-1:0]     active_cnt
);

   localparam int AW = $clog2(N_CH + 1);
   localparam logic [CNT_W-1:0] WAKE_LD = (WAKE_CYC > 0) ? CNT_W'(WAKE_CYC - 1) : '0;
   localparam logic [CNT_W-1:0] HOLD_LD = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_WAKE  = 2'd1,
      ST_ON    = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t           state_q [N_CH];
   state_t           state_d [N_CH];
   logic [CNT_W-1:0] cnt_q   [N_CH];
   logic [CNT_W-1:0] cnt_d   [N_CH];
   logic [N_CH-1:0]  gate_q;
   logic [N_CH-1:0]  gate_d;
   logic [AW-1:0]    active_d;
   logic [N_CH-1:0]  latch_in;
   logic [N_CH-1:0]  en_lat;

   // Per-channel next-state and counter update; gate follows the next state.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_OFF: begin
               if (clk_en[i]) begin
                  if (WAKE_CYC > 0) begin
                     state_d[i] = ST_WAKE;
                     cnt_d[i]   = WAKE_LD;
                  end else begin
                     state_d[i] = ST_ON;
                  end
               end
            end
            ST_WAKE: begin
               if (!clk_en[i]) begin
                  state_d[i] = ST_OFF;
               end else if (cnt_q[i] == '0) begin
                  state_d[i] = ST_ON;
               end else begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
               end
            end
            ST_ON: begin
               if (!clk_en[i]) begin
                  if (HOLD_CYC > 0) begin
                     state_d[i] = ST_DRAIN;
                     cnt_d[i]   = HOLD_LD;
                  end else begin
                     state_d[i] = ST_OFF;
                  end
               end
            end
            ST_DRAIN: begin
               if (clk_en[i]) begin
                  state_d[i] = ST_ON;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == '0) begin
                  state_d[i] = ST_OFF;
               end else begin
                  cnt_d[i] = cnt_q[i] - 1'b1;
               end
            end
            default: state_d[i] = ST_OFF;
         endcase
         gate_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_DRAIN);
      end
   end

   // Population count of the next gate vector so active_cnt tracks clk_ack exactly.
   always_comb begin
      active_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         active_d = active_d + AW'(gate_d[i]);
      end
   end

   // State, counters, gate enables and activity count, synchronous reset.
   always_ff @(posedge in_clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= ST_OFF;
            cnt_q[i]   <= '0;
         end
         gate_q     <= '0;
         active_cnt <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         gate_q     <= gate_d;
         active_cnt <= active_d;
      end
   end

`ifdef CLK_GATE_TEST_EN
   assign latch_in = gate_q | {N_CH{test_en}};
`else
   assign latch_in = gate_q;
`endif

   // Enable latch is open only while in_clk is low, so gate changes never cut a high phase.
   always_latch begin
      if (!in_clk) begin
         en_lat <= latch_in;
      end
   end

   assign out_clk = {N_CH{in_clk}} & en_lat;
   assign clk_ack = gate_q;

endmodule
